// File: rtl/dcache_banked_tile_mem_pkg.sv
// Shared types and helpers for the banked tile memory: FSM states, address
// field extraction and default geometry.
package dcache_pkg;

    localparam int SZ_DEF     = 4;
    localparam int LOGCNT_DEF = 5;
    localparam int BITS_DEF   = 18;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    // Low logcnt address bits pick the bank.
    function automatic logic [31:0] bank_sel(input logic [31:0] addr, input int logcnt);
        return addr & ((32'd1 << logcnt) - 32'd1);
    endfunction

    // The 10 bits above the bank field pick the word inside the bank.
    function automatic logic [31:0] word_sel(input logic [31:0] addr, input int logcnt);
        return (addr >> logcnt) & 32'h3FF;
    endfunction

endpackage

// File: rtl/dcache_banked_tile_mem_if.sv
// Request/response bundle between a tile port (master) and the banked tile memory (slave).
interface dcache_banked_tile_mem_if
    import dcache_pkg::*;
#(
    parameter int SZ     = SZ_DEF,
    parameter int LOGCNT = LOGCNT_DEF,
    parameter int BITS   = BITS_DEF
);
    localparam int LINE = BITS * SZ;
    localparam int AW   = 10 + LOGCNT;
    localparam int PW   = $clog2(SZ) + 1;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [AW-1:0]        req_addr;
    logic [AW-1:0]        req_stride_y;
    logic [LINE*SZ-1:0]   req_dat_w;
    logic                 resp_valid;
    logic [LINE*SZ-1:0]   resp_dat_r;
    logic [PW-1:0]        resp_passes;

    modport master (
        output req_valid, req_we, req_addr, req_stride_y, req_dat_w,
        input  req_ready, resp_valid, resp_dat_r, resp_passes
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_stride_y, req_dat_w,
        output req_ready, resp_valid, resp_dat_r, resp_passes
    );

endinterface

// File: rtl/dcache_banked_tile_mem_bank_ram.sv
// One LINE-wide, 1024-deep single-port bank with a registered read port.
module dcache_bank_ram #(
    parameter int LINE = 72
) (
    input  logic            clk,
    input  logic [9:0]      addr,
    input  logic [LINE-1:0] data_w,
    input  logic            we,
    input  logic            en,
    output logic [LINE-1:0] data_r
);
    logic [LINE-1:0] mem [1024];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= data_w;
            else    data_r    <= mem[addr];
        end
    end

endmodule

// File: rtl/dcache_banked_tile_mem.sv
// Strided tile memory over CNT banks; rows that collide on a bank are spread
// over several passes, lowest row first.
module dcache_banked_tile_mem
    import dcache_pkg::*;
#(
    parameter int SZ     = SZ_DEF,
    parameter int LOGCNT = LOGCNT_DEF,
    parameter int BITS   = BITS_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic freeze,
    dcache_banked_tile_mem_if.slave bus
);
    localparam int CNT  = 1 << LOGCNT;
    localparam int LINE = BITS * SZ;
    localparam int AW   = 10 + LOGCNT;
    localparam int PW   = $clog2(SZ) + 1;
    localparam int IW   = (SZ > 1) ? $clog2(SZ) : 1;

    state_t             state, state_nx;
    logic               we_r;
    logic [AW-1:0]      row_addr [SZ];
    logic [LINE-1:0]    row_dat  [SZ];
    logic [AW-1:0]      acc_addr [SZ];
    logic [LOGCNT-1:0]  row_bank [SZ];
    logic [9:0]         row_word [SZ];
    logic [SZ-1:0]      pending, grant, grant_r;
    logic [PW-1:0]      pass_cnt;
    logic [IW-1:0]      bank_pick [CNT];
    logic [LINE-1:0]    bank_q    [CNT];
    logic               resp_valid_q;
    logic [LINE*SZ-1:0] resp_dat_q;
    logic [PW-1:0]      resp_passes_q;
    logic               accept;

    assign bus.req_ready   = (state == IDLE) && !freeze;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_dat_r  = resp_dat_q;
    assign bus.resp_passes = resp_passes_q;
    assign accept          = bus.req_valid && bus.req_ready;

    always_comb begin
        for (int y = 0; y < SZ; y++) begin
            acc_addr[y] = bus.req_addr + bus.req_stride_y * AW'(y);
            row_bank[y] = LOGCNT'(bank_sel(32'(row_addr[y]), LOGCNT));
            row_word[y] = 10'(word_sel(32'(row_addr[y]), LOGCNT));
        end
    end

    for (genvar b = 0; b < CNT; b++) begin : g_bank
        logic          hit;
        logic [IW-1:0] pick;
        logic          en;
        logic          we;

        // Descending scan so the lowest pending row on this bank wins.
        always_comb begin
            hit  = 1'b0;
            pick = '0;
            for (int y = SZ - 1; y >= 0; y--) begin
                if (pending[y] && (row_bank[y] == LOGCNT'(b))) begin
                    hit  = 1'b1;
                    pick = IW'(y);
                end
            end
        end

        assign en           = (state == ISSUE) && hit && !freeze;
        assign we           = en && we_r;
        assign bank_pick[b] = pick;

        dcache_bank_ram #(.LINE(LINE)) u_ram (
            .clk    (clk),
            .addr   (row_word[pick]),
            .data_w (row_dat[pick]),
            .we     (we),
            .en     (en),
            .data_r (bank_q[b])
        );
    end

    always_comb begin
        for (int y = 0; y < SZ; y++) begin
            grant[y] = pending[y] && (bank_pick[row_bank[y]] == IW'(y));
        end
    end

    always_comb begin
        state_nx = state;
        if (!freeze) begin
            case (state)
                IDLE:    if (accept) state_nx = ISSUE;
                ISSUE:   if ((pending & ~grant) == '0) state_nx = CAPTURE;
                CAPTURE: state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_r          <= 1'b0;
            pending       <= '0;
            grant_r       <= '0;
            pass_cnt      <= '0;
            resp_valid_q  <= 1'b0;
            resp_dat_q    <= '0;
            resp_passes_q <= '0;
        end else if (!freeze) begin
            resp_valid_q <= 1'b0;
            // Bank outputs lag the access by one cycle, so capture follows grant_r.
            if (state != IDLE) begin
                for (int y = 0; y < SZ; y++) begin
                    if (grant_r[y] && !we_r) resp_dat_q[y*LINE +: LINE] <= bank_q[row_bank[y]];
                end
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_r     <= bus.req_we;
                        pending  <= '1;
                        grant_r  <= '0;
                        pass_cnt <= '0;
                    end
                end
                ISSUE: begin
                    pending  <= pending & ~grant;
                    grant_r  <= grant;
                    pass_cnt <= pass_cnt + 1'b1;
                end
                CAPTURE: begin
                    grant_r       <= '0;
                    resp_valid_q  <= 1'b1;
                    resp_passes_q <= pass_cnt;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int y = 0; y < SZ; y++) begin
                row_addr[y] <= acc_addr[y];
                row_dat[y]  <= bus.req_dat_w[y*LINE +: LINE];
            end
        end
    end

endmodule

// File: doc/dcache_banked_tile_mem.md
Name: dcache_banked_tile_mem

Overview:
- Banked tile memory for the data cache: one SZ-row tile per request, each row BITS*SZ bits wide, rows strided in address.
- Row y lives at address addr + stride_y*y. The low LOGCNT address bits select the bank; the upper 10 bits select the word within that bank.
- When two or more rows of a request map to the same bank, the request is serialised into multiple passes. This is the bank-conflict handling the strideless predecessor lacked.
- Sits behind the regfile/DMA tile ports. Supports a freeze stall.

Parameters:
- SZ, 4, rows per tile (also the number of BITS-wide elements per row).
- LOGCNT, 5, log2 of the bank count; CNT = 1<<LOGCNT banks.
- BITS, 18, bits per element; LINE = BITS*SZ bits per row/bank word.
- AW, 10+LOGCNT, tile address width (derived).
- PW, $clog2(SZ)+1, width of the pass counter (derived).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- freeze  in  1  global stall; holds all state and suppresses bank access.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE while freeze=0.
- req_we  in  1  1 = write tile, 0 = read tile.
- req_addr  in  AW  address of row 0.
- req_stride_y  in  AW  row stride.
- req_dat_w  in  LINE*SZ  write tile; row y is at [LINE*y +: LINE].
- resp_valid  out  1  one-cycle completion pulse, for reads and writes.
- resp_dat_r  out  LINE*SZ  read tile; valid while resp_valid=1 and a read completed.
- resp_passes  out  PW  number of passes used by the completed request.

Behaviour:
- Reset values: resp_valid=0, resp_dat_r=0, resp_passes=0; FSM returns to IDLE; the pending mask is cleared.
- Bank RAM contents are not reset.
- Reset mid-operation aborts the request silently; no resp_valid is produced.
- Accept: on a clock edge where req_valid && req_ready:
  - register req_we;
  - register each row address, computed as (req_addr + stride_y*y) mod 2^AW (wraps silently);
  - register the write rows;
  - set pending = all ones.
- FSM states and transitions:
  - IDLE: req_ready=1. Accept moves to ISSUE.
  - ISSUE: every bank is granted the lowest-index pending row that maps to it. Each granted bank is read or written (per req_we) at that row's 10-bit word address. Granted rows are cleared from pending, and the grant mask is registered. Stay in ISSUE while pending is non-zero after the grant; otherwise move to CAPTURE.
  - CAPTURE: capture the final pass's read data, set resp_valid=1, load resp_passes, go to IDLE.
- Read data path: bank data is valid the cycle after its access. On the next edge, each row set in the previous cycle's registered grant mask loads resp_dat_r from its bank's output. This capture happens both in ISSUE (for the previous pass) and in CAPTURE (for the last pass).
- Rows not read in a request keep their old resp_dat_r value. This only matters for writes, where resp_dat_r is left unchanged.
- Latency: n passes, n = max rows sharing one bank (1..SZ). Request accepted at edge E0 → resp_valid high in the cycle after edge E(n+1).
  - Conflict-free: 2 edges.
  - Worst case: SZ+1 edges.
- Throughput: resp_valid is high in IDLE, so the next request can be accepted in the same cycle (back-to-back).
- Write ordering: same-bank rows are written in ascending row order. With a duplicate word address, the highest row wins.
- freeze=1 in any state:
  - no state, counter, mask or output register changes;
  - bank we and read-enable are forced off;
  - req_ready=0;
  - resp_valid holds its value.
- req_valid while busy is ignored (req_ready=0). No request queueing.

Decomposition:
- Shared package dcache_pkg holds:
  - the FSM state enum (IDLE, ISSUE, CAPTURE);
  - bank-select and word-select field helpers (low LOGCNT bits / upper 10 bits);
  - default SZ/LOGCNT/BITS localparams.
- One sub-module, dcache_bank_ram: LINE-wide, 1024-deep, single-port, synchronous.
  - Inputs addr, data_w, we, en.
  - Registered read when en && !we.
  - Instantiated CNT times.
- Per-bank grant logic stays inline in a generate loop.

Test Plan:
- Conflict-free: write tile {row y = 0x100+y} at addr 0x0040, stride 1 → resp_passes=1, resp_valid 2 edges after accept. Read back → identical tile, resp_passes=1.
- Full conflict: addr 0x0000, stride 32 (all rows in bank 0) → resp_passes=4, resp_valid 5 edges after accept. Read-back matches the written rows.
- Partial conflict: addr 0x0000, stride 16 (banks 0,16,0,16) → resp_passes=2, latency 3 edges.
- Duplicate address: stride 0, write rows A,B,C,D → later read of addr returns D in all four rows, passes=4.
- Address wrap: addr 0x7FFF, stride 1 → row 1 maps to 0x0000 (bank 0, word 0). Verify via an independent read at 0x0000.
- Freeze for 3 cycles mid-ISSUE, then reset asserted mid-ISSUE:
  - freeze → latency extends by exactly 3 and data is correct;
  - reset → no resp_valid, req_ready=1 once reset is released.
